// File: rtl/divider_pkg.sv
// Shared types and defaults for the serial restoring divider.
package divider_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;

  localparam int DIV_WIDTH_DEFAULT = 16;

endpackage

// File: rtl/ripple_subtractor.sv
// Combinational A - B through a chain of full subtractors; BO is the borrow out of the MSB.
module ripple_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Diff,
  output logic             BO
);

  logic [WIDTH:0] borrow;

  assign borrow[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign Diff[i]       = A[i] ^ B[i] ^ borrow[i];
    assign borrow[i + 1] = (~A[i] & B[i]) | (~(A[i] ^ B[i]) & borrow[i]);
  end

  assign BO = borrow[WIDTH];

endmodule

// File: rtl/serial_restoring_divider.sv
// Restoring divider, one quotient bit per clock, Start/Done handshake.
// Define DIV_SIGNED_EN for two's-complement operands (magnitude core plus sign fix-up in DONE).
module serial_restoring_divider
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero,
  output logic [1:0]       fsm_state
);

  // Handshake: Start is sampled only in IDLE; Done is a one-cycle pulse and
  // Quotient/Remainder/DivByZero hold from that pulse until the next accepted Start.

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  div_state_t       state;
  logic [WIDTH-1:0] r_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] d_reg;
  logic [CW-1:0]    count;
  logic             dz;

  logic [WIDTH-1:0] dividend_mag;
  logic [WIDTH-1:0] divisor_mag;
  logic [WIDTH-1:0] quotient_fix;
  logic [WIDTH-1:0] remainder_fix;

`ifdef DIV_SIGNED_EN
  logic neg_q;
  logic neg_r;

  assign dividend_mag  = Dividend[WIDTH-1] ? (~Dividend + 1'b1) : Dividend;
  assign divisor_mag   = Divisor[WIDTH-1]  ? (~Divisor + 1'b1)  : Divisor;
  // Divide-by-zero results are raw values and bypass the sign fix-up.
  assign quotient_fix  = (neg_q && !dz) ? (~q_reg + 1'b1) : q_reg;
  assign remainder_fix = (neg_r && !dz) ? (~r_reg + 1'b1) : r_reg;
`else
  assign dividend_mag  = Dividend;
  assign divisor_mag   = Divisor;
  assign quotient_fix  = q_reg;
  assign remainder_fix = r_reg;
`endif

  // Shifted partial remainder; its top bit sits above the subtractor and forces "no borrow".
  logic [WIDTH-1:0] shifted_low;
  logic [WIDTH-1:0] trial_diff;
  logic             trial_bo;
  logic             no_borrow;

  assign shifted_low = {r_reg[WIDTH-2:0], q_reg[WIDTH-1]};
  assign no_borrow   = r_reg[WIDTH-1] | ~trial_bo;

  ripple_subtractor #(.WIDTH(WIDTH)) u_sub (
    .A    (shifted_low),
    .B    (d_reg),
    .Diff (trial_diff),
    .BO   (trial_bo)
  );

  assign Busy      = (state == RUN) || (state == DONE);
  assign fsm_state = state;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      r_reg     <= '0;
      q_reg     <= '0;
      d_reg     <= '0;
      count     <= '0;
      dz        <= 1'b0;
      Quotient  <= '0;
      Remainder <= '0;
      Done      <= 1'b0;
      DivByZero <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
`endif
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            DivByZero <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_q     <= Dividend[WIDTH-1] ^ Divisor[WIDTH-1];
            neg_r     <= Dividend[WIDTH-1];
`endif
            if (Divisor != '0) begin
              r_reg <= '0;
              q_reg <= dividend_mag;
              d_reg <= divisor_mag;
              count <= '0;
              dz    <= 1'b0;
              state <= RUN;
            end else begin
              r_reg <= Dividend;
              q_reg <= '1;
              dz    <= 1'b1;
              state <= DONE;
            end
          end
        end
        RUN: begin
          r_reg <= no_borrow ? trial_diff : shifted_low;
          q_reg <= {q_reg[WIDTH-2:0], no_borrow};
          count <= count + 1'b1;
          if (count == LAST) state <= DONE;
        end
        DONE: begin
          Done      <= 1'b1;
          DivByZero <= dz;
          Quotient  <= quotient_fix;
          Remainder <= remainder_fix;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_restoring_divider.sv
// Directed bench for serial_restoring_divider (WIDTH=16), signed vectors when DIV_SIGNED_EN is defined.
module tb_serial_restoring_divider;

  localparam int W = 16;

  logic         Clk = 1'b0;
  logic         Reset;
  logic         Start;
  logic [W-1:0] Dividend;
  logic [W-1:0] Divisor;
  logic [W-1:0] Quotient;
  logic [W-1:0] Remainder;
  logic         Busy;
  logic         Done;
  logic         DivByZero;
  logic [1:0]   fsm_state;

  int checks   = 0;
  int failures = 0;
  logic [2*W-1:0] exp_q[$];

  serial_restoring_divider #(.WIDTH(W)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .Dividend  (Dividend),
    .Divisor   (Divisor),
    .Quotient  (Quotient),
    .Remainder (Remainder),
    .Busy      (Busy),
    .Done      (Done),
    .DivByZero (DivByZero),
    .fsm_state (fsm_state)
  );

  // clock / reset
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver: one-cycle Start pulse; returns #1 after the accepting edge
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge Clk);
    Dividend = a;
    Divisor  = b;
    Start    = 1'b1;
    @(posedge Clk);
    #1;
    Start = 1'b0;
  endtask

  // counts edges until Done is seen (bounded)
  task automatic wait_done(output int edges);
    edges = 0;
    do begin
      @(posedge Clk);
      #1;
      edges++;
    end while (!Done && edges < 40);
  endtask

  task automatic check_result(input string tag, input logic exp_dz);
    logic [2*W-1:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_q"}, 32'(Quotient), 32'(e[2*W-1:W]));
      check({tag, "_r"}, 32'(Remainder), 32'(e[W-1:0]));
      check({tag, "_dz"}, 32'(DivByZero), 32'(exp_dz));
    end
  endtask

  task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic exp_dz, input int exp_lat);
    int n;
    exp_q.push_back({eq, er});
    start_op(a, b);
    check({tag, "_busy"}, 32'(Busy), 32'd1);
    wait_done(n);
    check({tag, "_lat"}, 32'(n), 32'(exp_lat));
    check_result(tag, exp_dz);
    check({tag, "_busy_after"}, 32'(Busy), 32'd0);
  endtask

  initial begin
    int n;
    Reset    = 1'b1;
    Start    = 1'b0;
    Dividend = '0;
    Divisor  = '0;
    repeat (3) @(posedge Clk);
    #1;
    check("rst_q", 32'(Quotient), 32'd0);
    check("rst_r", 32'(Remainder), 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_dz", 32'(DivByZero), 32'd0);
    check("rst_state", 32'(fsm_state), 32'd0);
    @(negedge Clk);
    Reset = 1'b0;

    run_div("d100_7", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 17);
    repeat (3) @(posedge Clk);
    #1;
    check("hold_q", 32'(Quotient), 32'd14);
    check("hold_done", 32'(Done), 32'd0);

    run_div("ffff_1", 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 17);
    run_div("3_8000", 16'd3, 16'h8000, 16'h0000, 16'h0003, 1'b0, 17);
    run_div("ffff_ffff", 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 17);
    run_div("div0", 16'd1234, 16'd0, 16'hFFFF, 16'd1234, 1'b1, 1);
    run_div("after_div0", 16'd50, 16'd5, 16'd10, 16'd0, 1'b0, 17);

    // Start pulsed mid-RUN with new operands must be ignored
    exp_q.push_back({16'd142, 16'd6});
    start_op(16'd1000, 16'd7);
    repeat (4) @(posedge Clk);
    @(negedge Clk);
    Dividend = 16'd5;
    Divisor  = 16'd1;
    Start    = 1'b1;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    wait_done(n);
    check("midrun_lat", 32'(n), 32'd12);
    check_result("midrun", 1'b0);
    repeat (2) @(posedge Clk);
    #1;
    check("midrun_idle", 32'(Busy), 32'd0);

    // Start held high: second operation accepted in the IDLE cycle after Done
    exp_q.push_back({16'd21, 16'd1});
    exp_q.push_back({16'd100, 16'd0});
    @(negedge Clk);
    Dividend = 16'd64;
    Divisor  = 16'd3;
    Start    = 1'b1;
    @(posedge Clk);
    #1;
    wait_done(n);
    check("held1_lat", 32'(n), 32'd17);
    check_result("held1", 1'b0);
    Dividend = 16'd1000;
    Divisor  = 16'd10;
    wait_done(n);
    check("held2_lat", 32'(n), 32'd18);
    check_result("held2", 1'b0);
    Start = 1'b0;

`ifdef DIV_SIGNED_EN
    run_div("s_m7_2", 16'hFFF9, 16'd2, 16'hFFFD, 16'hFFFF, 1'b0, 17);
    run_div("s_7_m2", 16'd7, 16'hFFFE, 16'hFFFD, 16'h0001, 1'b0, 17);
    run_div("s_min_m1", 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 17);
    run_div("s_div0", 16'hFFF0, 16'd0, 16'hFFFF, 16'hFFF0, 1'b1, 1);
`endif

    // Reset asserted in the middle of RUN aborts immediately
    start_op(16'd100, 16'd7);
    repeat (5) @(posedge Clk);
    #1;
    Reset = 1'b1;
    #1;
    check("abort_state", 32'(fsm_state), 32'd0);
    check("abort_busy", 32'(Busy), 32'd0);
    check("abort_q", 32'(Quotient), 32'd0);
    check("abort_r", 32'(Remainder), 32'd0);
    check("abort_done", 32'(Done), 32'd0);
    check("abort_dz", 32'(DivByZero), 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check("abort_no_done", 32'(Done), 32'd0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
